uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: uart_tick_16x  input  1  one-clock pulse at 16x baud, synchronous to clock.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port: read_ack  input  1  one-clock pulse; consumer has taken data.
REQ-006 SHALL have port: data  output  8  last received byte.
REQ-007 SHALL have port: data_valid  output  1  level; byte held in data and not yet acknowledged.
REQ-008 SHALL have port: overrun  output  1  sticky; a completed byte overwrote an unacknowledged byte.
REQ-009 SHALL have port: framing_error  output  1  one-clock pulse; stop bit sampled low.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer (reset value 1) before any use; rx_s is the synchronizer output.
REQ-011 SHALL advance the state machine and the 4-bit tick counter only on clocks where uart_tick_16x=1.
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 IDLE: on a tick with rx_s=0, clear the tick counter to 0 and go to START.
REQ-014 START: increment the counter per tick; at counter=7, sample; sample=0 -> clear counter, clear bit index, go to DATA; sample=1 -> glitch, go to IDLE.
REQ-015 DATA: increment the counter per tick, wrapping 15->0; at counter=15, shift the sample into bit[index] (LSB first) and increment the 3-bit index; after the sample at index 7, go to STOP.
REQ-016 STOP: at counter=15, sample; go to IDLE regardless of the sampled value.
REQ-017 Stop sample=1: on the next clock, load data with the shift register and set data_valid=1.
REQ-018 Stop sample=0: on the next clock, pulse framing_error for one clock; discard the byte; leave data, data_valid and overrun unchanged.
REQ-019 read_ack with no byte completing: clear data_valid and overrun on the next clock; read_ack while data_valid=0 has no effect.
REQ-020 Byte completes while data_valid=1 and read_ack=0: overwrite data, keep data_valid=1, set overrun=1.
REQ-021 Byte completes in the same cycle as read_ack: load the new byte, keep data_valid=1, clear overrun.
REQ-022 Held-low line (break): repeated START->DATA->STOP cycles, each ending in a framing_error pulse; no lock-up.
REQ-023 Latency: data_valid SHALL rise exactly one clock after the stop-sample tick.

Reset
REQ-024 On reset_n=0, immediately: state=IDLE, counter=0, index=0, shift register=0, synchronizer flops=1, data=0x00, data_valid=0, overrun=0, framing_error=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no output pulse; after release, reception starts only on a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_MAJORITY_EN defined: each sample SHALL be the 2-of-3 majority of rx_s captured on the current tick and the two preceding ticks.
REQ-027 Macro UART_RX_MAJORITY_EN undefined: each sample SHALL be the single rx_s value on the current tick; the 3-entry sample history SHALL not be instantiated.

Structure
REQ-028 Package uart_pkg SHALL hold the state enumeration, OVERSAMPLE=16, START_SAMPLE=7, BIT_SAMPLE=15 and DATA_BITS=8.
REQ-029 The synchronizer SHALL be a sub-module named uart_sync2 (reset value a parameter); all other logic SHALL be in uart_rx.

Verification
Bench setup: uart_tick_16x every 4 clocks; one bit = 64 clocks.
REQ-030 Send 0x55 with a valid stop bit -> data=0x55, data_valid=1 one clock after the stop tick, framing_error never pulses.
REQ-031 Send 0xA3 and 0x3C back-to-back with no read_ack -> data=0x3C, data_valid=1, overrun=1; then read_ack -> data_valid=0, overrun=0.
REQ-032 Send 0x81 with stop bit=0 -> one framing_error pulse; data, data_valid and overrun unchanged.
REQ-033 Drive a 5-tick low glitch on the idle line -> return to IDLE; no data_valid, no framing_error.
REQ-034 Assert reset_n=0 during bit 4 of 0xF0, release, then send 0x12 -> only 0x12 is received.
REQ-035 With UART_RX_MAJORITY_EN defined, inject a one-tick inverted spike at a data-bit sample point of 0x5A -> data=0x5A; without the macro -> data differs in that bit.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver: receive state enumeration and the
// oversampling / sample-point constants.
//
// Optional feature macro used by uart_rx: UART_RX_MAJORITY_EN
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int CNT_W      = $clog2(OVERSAMPLE);
    localparam int IDX_W      = $clog2(DATA_BITS);

    // Tick-counter values at which the line is sampled.
    localparam logic [CNT_W-1:0] START_SAMPLE = 4'd7;
    localparam logic [CNT_W-1:0] BIT_SAMPLE   = 4'd15;

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for a single asynchronous input bit.
//
// Parameters:
//   RESET_VAL - value both flops take while reset_n is low
// Ports:
//   clock    in   sampling clock
//   reset_n  in   asynchronous active-low reset
//   d        in   asynchronous input
//   q        out  synchronized output (two clocks of latency)
// -----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, 16x oversampled. The start bit is verified at
// its middle (tick 7), each data bit and the stop bit are sampled 16 ticks
// later. A good stop bit loads the byte into data one clock after the stop
// sample; a low stop bit produces a one-clock framing_error pulse instead.
//
// Optional feature (macro UART_RX_MAJORITY_EN): every sample is the 2-of-3
// majority of rx_s on the current tick and the two preceding ticks. Without the
// macro the sample is rx_s on the current tick.
//
// Ports:
//   clock          in   sole clock
//   reset_n        in   asynchronous active-low reset
//   uart_tick_16x  in   one-clock pulse at 16x baud
//   rx             in   asynchronous serial line, idle high
//   read_ack       in   one-clock pulse, consumer took data
//   data           out  last received byte
//   data_valid     out  byte held in data and not yet acknowledged
//   overrun        out  sticky, unacknowledged byte was overwritten
//   framing_error  out  one-clock pulse, stop bit sampled low
//   state_dbg      out  current receive state (observation only)
//
// Output handshake: data_valid is a level that rises when a byte lands in data
// and falls on the clock after read_ack; a read_ack while data_valid is low is
// ignored. A byte landing in the same clock as read_ack wins (data_valid stays
// high, overrun clears).
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 uart_tick_16x,
    input  logic                 rx,
    input  logic                 read_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 overrun,
    output logic                 framing_error,
    output uart_state_t          state_dbg
);

    logic rx_s;
    logic sample;

    uart_state_t          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 byte_ok;
    logic                 byte_bad;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // rx_s from the two previous ticks; shifts on every tick in every state so
    // the history is already filled when a sample point arrives.
    logic [1:0] hist;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist <= 2'b11;
        end else if (uart_tick_16x) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign sample = rx_s;
`endif

    // State register and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    // Next-state logic. Nothing moves except on a tick.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shreg_n  = shreg;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;

        if (uart_tick_16x) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt_n   = '0;
                        state_n = ST_START;
                    end
                end

                ST_START: begin
                    if (cnt == START_SAMPLE) begin
                        cnt_n = '0;
                        if (!sample) begin
                            idx_n   = '0;
                            state_n = ST_DATA;
                        end else begin
                            // Start bit did not hold to mid-bit: treat as a glitch.
                            state_n = ST_IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    // Free-running wrap 15->0 keeps each bit exactly 16 ticks.
                    cnt_n = cnt + 1'b1;
                    if (cnt == BIT_SAMPLE) begin
                        shreg_n[idx] = sample;
                        idx_n        = idx + 1'b1;
                        if (idx == IDX_W'(DATA_BITS - 1)) begin
                            state_n = ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == BIT_SAMPLE) begin
                        cnt_n    = '0;
                        state_n  = ST_IDLE;
                        byte_ok  = sample;
                        byte_bad = ~sample;
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Output holding register and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data          <= '0;
            data_valid    <= 1'b0;
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= byte_bad;
            if (byte_ok) begin
                data       <= shreg;
                data_valid <= 1'b1;
                // A simultaneous read_ack consumed the old byte, so no overrun.
                overrun    <= ~read_ack & (data_valid | overrun);
            end else if (read_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

    assign state_dbg = state;

endmodule
